// File: rtl/visor_bp_pkg.sv
// visor_bp_pkg -- shared definitions for the visor breakpoint unit.
//
// Contents:
//   bp_state_t  : breakpoint FSM encoding (RUN, PEND, HALT, STEP)
//   idx_width() : width of a channel index, max(1, $clog2(n)), usable in
//                 constant expressions such as port widths.
//
// Optional feature macro used by files importing this package:
//   VISOR_BP_PASSCOUNT_EN -- per-channel pass counters.
package visor_bp_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,  // target free-running, comparators armed
    ST_PEND = 2'd1,  // match seen, waiting for the exec cycle
    ST_HALT = 2'd2,  // target stalled, ready withheld
    ST_STEP = 2'd3   // releasing exactly one exec, then back to HALT
  } bp_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/visor_bp_chan.sv
// visor_bp_chan -- one breakpoint channel: enable, address and pass count
// registers plus the address comparator.
//
// Configuration macro: VISOR_BP_PASSCOUNT_EN
//   defined   : a pass counter is kept; i_dec decrements it, saturating at 0.
//   undefined : no counter registers; o_count_zero is tied high so every
//               qualified hit halts, and i_cfg_count / i_dec are unused.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_cfg_we            load enable/address/count this cycle
//   i_cfg_addr/count/en configuration values
//   i_addr              target fetch address being compared
//   i_dec               consume one pass of this channel
//   o_match             channel enabled and address equal
//   o_count_zero        pass count exhausted (next qualified hit halts)
module visor_bp_chan
  import visor_bp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cfg_we,
  input  logic [ADDR_WIDTH-1:0]  i_cfg_addr,
  input  logic [COUNT_WIDTH-1:0] i_cfg_count,
  input  logic                   i_cfg_en,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic                   i_dec,
  output logic                   o_match,
  output logic                   o_count_zero
);

  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en   <= 1'b0;
      r_addr <= '0;
    end else if (i_cfg_we) begin
      r_en   <= i_cfg_en;
      r_addr <= i_cfg_addr;
    end
  end

  // A disabled channel never matches, whatever its stored address.
  assign o_match = r_en && (i_addr == r_addr);

`ifdef VISOR_BP_PASSCOUNT_EN
  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_cfg_we) begin
      r_count <= i_cfg_count;
    end else if (i_dec && (r_count != '0)) begin
      // Saturating: a stray decrement at zero must not wrap to all-ones.
      r_count <= r_count - COUNT_WIDTH'(1);
    end
  end

  assign o_count_zero = (r_count == '0);
`else
  logic w_unused_cnt;

  assign w_unused_cnt = ^{i_cfg_count, i_dec};
  assign o_count_zero = 1'b1;
`endif

endmodule

// File: rtl/visor_bp_unit.sv
// visor_bp_unit -- instruction-fetch breakpoint unit for a visor-controlled
// target. NUM_BP channels compare the fetch address; a lowest-index priority
// encoder picks the hit channel and a four-state FSM stalls the target by
// withholding fetch ready.
//
// Configuration macro: VISOR_BP_PASSCOUNT_EN (see visor_bp_chan). Without it
// every qualified hit halts immediately.
//
// Ports:
//   sysclk, sysreset        clock, asynchronous active-high reset
//   tg_code_addr            target fetch address
//   tg_enable_exec          target executes the fetched instruction this cycle
//   rom_code_ready          ready from code ROM
//   tg_code_ready           ready to target (ROM ready, forced low in HALT)
//   cfg_wr/sel/addr/count/en channel configuration write
//   step_req, resume        visor commands, acted on only in HALT
//   bp_hit                  target halted
//   hit_index               channel responsible for the current halt
//   step_done               one-cycle pulse after a single step completes
//   dbg_state               current FSM state
//
// Fetch handshake: the target fetch completes in a cycle where
// tg_code_ready is high. This unit never delays ready -- tg_code_ready is a
// purely combinational copy of rom_code_ready -- except in HALT, where it is
// held low so the target cannot advance; the target keeps its address stable
// until ready is seen.
module visor_bp_unit
  import visor_bp_pkg::*;
#(
  parameter  int NUM_BP      = 4,
  parameter  int ADDR_WIDTH  = 16,
  parameter  int COUNT_WIDTH = 8,
  localparam int IW          = idx_width(NUM_BP)
) (
  input  logic                   sysclk,
  input  logic                   sysreset,
  input  logic [ADDR_WIDTH-1:0]  tg_code_addr,
  input  logic                   tg_enable_exec,
  input  logic                   rom_code_ready,
  output logic                   tg_code_ready,
  input  logic                   cfg_wr,
  input  logic [IW-1:0]          cfg_sel,
  input  logic [ADDR_WIDTH-1:0]  cfg_addr,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  input  logic                   cfg_en,
  input  logic                   step_req,
  input  logic                   resume,
  output logic                   bp_hit,
  output logic [IW-1:0]          hit_index,
  output logic                   step_done,
  output bp_state_t              dbg_state
);

  bp_state_t       r_state;
  logic [IW-1:0]   r_pend_idx;
  logic [IW-1:0]   r_hit_idx;
  logic            r_step_done;

  logic [NUM_BP-1:0] w_cfg_we;
  logic [NUM_BP-1:0] w_match;
  logic [NUM_BP-1:0] w_cnt_zero;
  logic [NUM_BP-1:0] w_dec;

  logic            w_any_match;
  logic [IW-1:0]   w_enc_idx;
  logic            w_zero_enc;
  logic            w_zero_pend;

  bp_state_t       w_next_state;
  logic            w_pend_load;
  logic            w_halt_load;
  logic [IW-1:0]   w_halt_idx;
  logic            w_dec_req;
  logic [IW-1:0]   w_dec_idx;
  logic            w_step_fin;

  // ---------------------------------------------------------------- channels
  for (genvar g = 0; g < NUM_BP; g++) begin : g_chan
    assign w_cfg_we[g] = cfg_wr && (cfg_sel == IW'(g));
    assign w_dec[g]    = w_dec_req && (w_dec_idx == IW'(g));

    visor_bp_chan #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_chan (
      .i_clk        (sysclk),
      .i_rst        (sysreset),
      .i_cfg_we     (w_cfg_we[g]),
      .i_cfg_addr   (cfg_addr),
      .i_cfg_count  (cfg_count),
      .i_cfg_en     (cfg_en),
      .i_addr       (tg_code_addr),
      .i_dec        (w_dec[g]),
      .o_match      (w_match[g]),
      .o_count_zero (w_cnt_zero[g])
    );
  end

  // ------------------------------------------------------- priority encoder
  // Scanning downward leaves the lowest matching index in w_enc_idx.
  always_comb begin
    w_any_match = |w_match;
    w_enc_idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (w_match[i]) w_enc_idx = IW'(i);
    end
  end

  // Count-exhausted flag of the freshly encoded channel (hit and exec in the
  // same cycle) and of the channel latched on entry to PEND.
  always_comb begin
    w_zero_enc  = 1'b1;
    w_zero_pend = 1'b1;
    for (int i = 0; i < NUM_BP; i++) begin
      if (w_enc_idx == IW'(i))  w_zero_enc  = w_cnt_zero[i];
      if (r_pend_idx == IW'(i)) w_zero_pend = w_cnt_zero[i];
    end
  end

  // -------------------------------------------------------------------- FSM
  always_comb begin
    w_next_state = r_state;
    w_pend_load  = 1'b0;
    w_halt_load  = 1'b0;
    w_halt_idx   = r_pend_idx;
    w_dec_req    = 1'b0;
    w_dec_idx    = r_pend_idx;
    w_step_fin   = 1'b0;

    if (cfg_wr) begin
      // Reconfiguration abandons any pending hit, halt or step.
      w_next_state = ST_RUN;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_any_match) begin
            if (tg_enable_exec) begin
              // Exec lands in the match cycle: resolve without visiting PEND.
              if (w_zero_enc) begin
                w_next_state = ST_HALT;
                w_halt_load  = 1'b1;
                w_halt_idx   = w_enc_idx;
              end else begin
                w_dec_req    = 1'b1;
                w_dec_idx    = w_enc_idx;
              end
            end else begin
              w_next_state = ST_PEND;
              w_pend_load  = 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (tg_enable_exec) begin
            if (w_zero_pend) begin
              w_next_state = ST_HALT;
              w_halt_load  = 1'b1;
            end else begin
              w_next_state = ST_RUN;
              w_dec_req    = 1'b1;
            end
          end
        end
        ST_HALT: begin
          // Step wins when both commands arrive together.
          if (step_req)    w_next_state = ST_STEP;
          else if (resume) w_next_state = ST_RUN;
        end
        ST_STEP: begin
          // Comparator hits are ignored here so the step can leave the
          // breakpoint address without re-triggering on it.
          if (tg_enable_exec) begin
            w_next_state = ST_HALT;
            w_step_fin   = 1'b1;
          end
        end
        default: w_next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      r_state     <= ST_RUN;
      r_pend_idx  <= '0;
      r_hit_idx   <= '0;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_step_done <= w_step_fin;
      if (w_pend_load) r_pend_idx <= w_enc_idx;
      if (w_halt_load) r_hit_idx  <= w_halt_idx;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bp_hit        = (r_state == ST_HALT);
  assign tg_code_ready = (r_state == ST_HALT) ? 1'b0 : rom_code_ready;
  assign hit_index     = r_hit_idx;
  assign step_done     = r_step_done;
  assign dbg_state     = r_state;

endmodule

// File: doc/visor_bp_unit.md
VISOR_BP_UNIT -- requirements
Module: visor_bp_unit

Interface
REQ-001 SHALL have parameter NUM_BP, default 4, number of breakpoint channels (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, width of the target code address.
REQ-003 SHALL have parameter COUNT_WIDTH, default 8, width of the per-channel pass counter.
REQ-004 SHALL have port sysclk  in  1  sole clock, rising edge.
REQ-005 SHALL have port sysreset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port tg_code_addr  in  ADDR_WIDTH  target fetch address.
REQ-007 SHALL have port tg_enable_exec  in  1  target debug_out enable_exec flag, marking an ordinary assignment cycle.
REQ-008 SHALL have port rom_code_ready  in  1  ready from the target code ROM.
REQ-009 SHALL have port tg_code_ready  out  1  gated ready to the target.
REQ-010 SHALL have port cfg_wr  in  1  single-cycle channel configuration strobe.
REQ-011 SHALL have port cfg_sel  in  $clog2(NUM_BP) (min 1)  channel index for cfg_wr.
REQ-012 SHALL have port cfg_addr, cfg_count, cfg_en  in  ADDR_WIDTH, COUNT_WIDTH, 1  channel address, pass count and enable.
REQ-013 SHALL have port step_req, resume  in  1 each  single-cycle visor commands.
REQ-014 SHALL have port bp_hit  out  1  target is halted.
REQ-015 SHALL have port hit_index  out  $clog2(NUM_BP) (min 1)  channel that caused the halt.
REQ-016 SHALL have port step_done  out  1  one-cycle pulse when a single step completes.

Function
- REQ-017 Matching:
  - A channel SHALL match when it is enabled and tg_code_addr equals its address.
  - Disabled channels SHALL never match.
- REQ-018 FSM states SHALL be RUN, PEND, HALT and STEP.
- REQ-019 RUN SHALL go to PEND on any match, latching the lowest matching channel index.
- REQ-020 PEND SHALL act on the next tg_enable_exec, which may fall in the matching cycle itself:
  - latched channel pass count zero -> HALT;
  - nonzero -> decrement the count by 1 and return to RUN.
- REQ-021 HALT SHALL hold bp_hit=1 and tg_code_ready=0.
- REQ-022 Outside HALT, tg_code_ready SHALL equal rom_code_ready, combinationally with no added latency.
- REQ-023 HALT SHALL go to RUN on resume and clear bp_hit in the following cycle.
- REQ-024 Single step:
  - HALT SHALL go to STEP on step_req.
  - STEP SHALL pass rom_code_ready through until exactly one tg_enable_exec.
  - STEP SHALL then return to HALT, pulse step_done for 1 cycle, and leave hit_index unchanged.
- REQ-025 step_req and resume asserted together SHALL execute the step; resume SHALL be ignored.
- REQ-026 step_req or resume outside HALT SHALL be ignored.
- REQ-027 cfg_wr SHALL have these effects:
  - update the selected channel in the same clock edge;
  - force the FSM to RUN and clear bp_hit, regardless of state;
  - take priority over every simultaneous match, exec or command.
- REQ-028 Matches in STEP SHALL be ignored, so a step never re-halts on the address it leaves.
- REQ-029 The pass-count decrement SHALL saturate at zero and never wrap.

Reset
- REQ-030 sysreset SHALL asynchronously produce:
  - FSM in RUN, bp_hit=0, hit_index=0, step_done=0;
  - every channel disabled, with address 0 and count 0.
- REQ-031 Assertion mid-step or mid-halt SHALL abandon the operation with no step_done pulse.
- REQ-032 tg_code_ready SHALL follow rom_code_ready during reset.

Configuration
- REQ-033 With VISOR_BP_PASSCOUNT_EN defined:
  - pass counters SHALL exist;
  - REQ-020 applies as written.
- REQ-034 Without VISOR_BP_PASSCOUNT_EN:
  - no counter registers SHALL exist and cfg_count SHALL be ignored;
  - PEND SHALL always go to HALT.

Structure
- REQ-035 Package visor_bp_pkg SHALL hold:
  - the FSM state enum (RUN, PEND, HALT, STEP);
  - a localparam function for index width, max(1, $clog2(N)).
- REQ-036 Sub-module visor_bp_chan SHALL hold one channel's registers, its comparator and its counter.
- REQ-037 The top SHALL instantiate NUM_BP visor_bp_chan instances and implement the priority encoder and FSM.

Verification
- REQ-038 Basic halt:
  - Stimulus: ch1 addr=0x0040, count=0, en=1; address 0x0040 with exec one cycle later.
  - Response: bp_hit=1 and hit_index=1 next cycle; tg_code_ready=0.
- REQ-039 Pass count:
  - Stimulus: ch0 count=2; address hit three times.
  - Response: halt only on the 3rd hit; count reads 0.
  - Without the macro: halt on the 1st hit.
- REQ-040 Priority:
  - Stimulus: ch0 and ch3 both at 0x0100.
  - Response: hit_index=0.
  - Stimulus: ch0 disabled.
  - Response: hit_index=3.
- REQ-041 Step:
  - Stimulus: halted; step_req and resume in the same cycle; one exec.
  - Response: step_done pulses once, FSM returns to HALT, hit_index unchanged.
- REQ-042 Config and reset:
  - Stimulus: cfg_wr during PEND.
  - Response: RUN with no halt.
  - Stimulus: sysreset during STEP.
  - Response: bp_hit=0, no step_done, all channels disabled.
